// File: rtl/sr_run_ctrl.sv
// rtl/sr_run_ctrl.sv - load-and-run controller for a soft CPU with pass/fail watchdog
//
// Streams a program into instruction RAM, holds the CPU in reset for two
// BOOT cycles, releases it, then watches one debug register for a pass
// signature. Optional watchdog (macro SR_RUN_CTRL_WATCHDOG_EN) fails the
// run when the run counter reaches TIMEOUT without a match.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start             one-cycle request to begin load-and-run (IDLE/DONE only)
//   ld_valid/ld_ready load word handshake; ld_data word, ld_last end of program
//   im_we/im_waddr/im_wdata  instruction RAM write port
//   cpu_rst           active-high CPU reset, low only in RUN
//   dbg_addr/dbg_data CPU debug register read port
//   busy              high in LOAD, BOOT, RUN
//   pass/fail         sticky result flags, cleared by an accepted start
module sr_run_ctrl #(
  parameter int          IMEM_DEPTH = 64,
  parameter logic [31:0] EXPECT     = 32'h00213d05,
  parameter int          DBG_REG    = 10,
  parameter int          TIMEOUT    = 255
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic                          ld_valid,
  output logic                          ld_ready,
  input  logic [31:0]                   ld_data,
  input  logic                          ld_last,
  output logic                          im_we,
  output logic [$clog2(IMEM_DEPTH)-1:0] im_waddr,
  output logic [31:0]                   im_wdata,
  output logic                          cpu_rst,
  output logic [4:0]                    dbg_addr,
  input  logic [31:0]                   dbg_data,
  output logic                          busy,
  output logic                          pass,
  output logic                          fail
);

  localparam int AW = $clog2(IMEM_DEPTH);
  // Run counter is at least 8 bits and wide enough to hold TIMEOUT.
  localparam int CW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  localparam logic [AW-1:0] LAST_ADDR = AW'(IMEM_DEPTH - 1);
  localparam logic [CW-1:0] RUN_LIMIT = CW'(TIMEOUT);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    BOOT = 3'd2,
    RUN  = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [AW-1:0] wptr;
  logic [CW-1:0] run_cnt;
  logic          boot_cnt;
  logic          pass_q;

  logic xfer;
  logic load_end;
  logic accept_start;
  logic match;

  assign xfer         = ld_valid & ld_ready;
  // The last RAM slot ends the load even without ld_last, so wptr never
  // wraps onto word 0 with a write.
  assign load_end     = xfer & (ld_last | (wptr == LAST_ADDR));
  assign accept_start = start & ((state == IDLE) | (state == DONE));
  assign match        = (state == RUN) & (dbg_data == EXPECT);

`ifdef SR_RUN_CTRL_WATCHDOG_EN
  logic timeout;
  logic fail_q;
  // A match in the same cycle takes priority over the timeout.
  assign timeout = (state == RUN) & (run_cnt == RUN_LIMIT) & ~match;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept_start) state_nxt = LOAD;
      LOAD:    if (load_end) state_nxt = BOOT;
      BOOT:    if (boot_cnt) state_nxt = RUN;
      RUN: begin
        if (match) begin
          state_nxt = DONE;
        end
`ifdef SR_RUN_CTRL_WATCHDOG_EN
        else if (timeout) begin
          state_nxt = DONE;
        end
`endif
      end
      DONE:    if (accept_start) state_nxt = LOAD;
      default: state_nxt = IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    ld_ready = 1'b0;
    cpu_rst  = 1'b1;
    busy     = 1'b0;
    case (state)
      LOAD: begin
        ld_ready = 1'b1;
        busy     = 1'b1;
      end
      BOOT: begin
        busy = 1'b1;
      end
      RUN: begin
        cpu_rst = 1'b0;
        busy    = 1'b1;
      end
      default: begin
        ld_ready = 1'b0;
      end
    endcase
  end

  assign im_we    = xfer;
  assign im_waddr = wptr;
  assign im_wdata = ld_data;
  assign dbg_addr = 5'(DBG_REG);
  assign pass     = pass_q;

  // Write pointer, boot/run counters and pass flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr     <= '0;
      run_cnt  <= '0;
      boot_cnt <= 1'b0;
      pass_q   <= 1'b0;
    end else begin
      if (accept_start) begin
        wptr   <= '0;
        pass_q <= 1'b0;
      end else if (xfer) begin
        wptr <= wptr + 1'b1;
      end

      if (load_end) begin
        run_cnt  <= '0;
        boot_cnt <= 1'b0;
      end else if (state == BOOT) begin
        boot_cnt <= 1'b1;
      end else if ((state == RUN) && (run_cnt != RUN_LIMIT)) begin
        run_cnt <= run_cnt + 1'b1;
      end

      if (match) begin
        pass_q <= 1'b1;
      end
    end
  end

`ifdef SR_RUN_CTRL_WATCHDOG_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fail_q <= 1'b0;
    end else if (accept_start) begin
      fail_q <= 1'b0;
    end else if (timeout) begin
      fail_q <= 1'b1;
    end
  end

  assign fail = fail_q;
`else
  assign fail = 1'b0;
`endif

endmodule

// File: tb/tb_sr_run_ctrl.sv
// tb/tb_sr_run_ctrl.sv - directed self-checking bench for sr_run_ctrl
module tb_sr_run_ctrl;

  localparam int          DEPTH = 64;
  localparam logic [31:0] EXP   = 32'h00213d05;
  localparam int          TMO   = 255;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        ld_valid;
  logic        ld_ready;
  logic [31:0] ld_data;
  logic        ld_last;
  logic        im_we;
  logic [5:0]  im_waddr;
  logic [31:0] im_wdata;
  logic        cpu_rst;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data;
  logic        busy;
  logic        pass;
  logic        fail;

  int n_tests = 0;
  int n_fail  = 0;

  sr_run_ctrl #(
    .IMEM_DEPTH(DEPTH),
    .EXPECT    (EXP),
    .DBG_REG   (10),
    .TIMEOUT   (TMO)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .ld_valid(ld_valid),
    .ld_ready(ld_ready),
    .ld_data (ld_data),
    .ld_last (ld_last),
    .im_we   (im_we),
    .im_waddr(im_waddr),
    .im_wdata(im_wdata),
    .cpu_rst (cpu_rst),
    .dbg_addr(dbg_addr),
    .dbg_data(dbg_data),
    .busy    (busy),
    .pass    (pass),
    .fail    (fail)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // From IDLE/DONE: start, stream n words with ld_valid held high, pass
  // through both BOOT cycles; returns in the first RUN cycle.
  task automatic load_and_boot(input int n);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < n; i++) begin
      ld_valid = 1'b1;
      ld_data  = 32'hC000_0000 + i;
      ld_last  = (i == n - 1);
      tick();
    end
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    rst_n    = 1'b1;
    start    = 1'b0;
    ld_valid = 1'b1;
    ld_data  = 32'h0;
    ld_last  = 1'b0;
    dbg_data = EXP;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_cpu_rst", cpu_rst, 1);
    chk("rst_ld_ready", ld_ready, 0);
    chk("rst_im_we", im_we, 0);
    chk("rst_pass", pass, 0);
    chk("rst_fail", fail, 0);
    chk("dbg_addr", dbg_addr, 10);
    tick();
    tick();
    rst_n    = 1'b1;
    ld_valid = 1'b0;
    repeat (3) tick();
    chk("idle_hold_busy", busy, 0);
    chk("idle_hold_pass", pass, 0);
    dbg_data = 32'h0;

    // Load-and-pass: 4 words, ld_valid held high
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("load_ready", ld_ready, 1);
    for (int i = 0; i < 4; i++) begin
      ld_valid = 1'b1;
      ld_data  = 32'hA000_0000 + i;
      ld_last  = (i == 3);
      #1;
      chk("p1_we", im_we, 1);
      chk("p1_waddr", im_waddr, i);
      chk("p1_wdata", im_wdata, 32'hA000_0000 + i);
      tick();
    end
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    chk("boot1_ready", ld_ready, 0);
    chk("boot1_cpu_rst", cpu_rst, 1);
    chk("boot1_busy", busy, 1);
    tick();
    chk("boot2_cpu_rst", cpu_rst, 1);
    dbg_data = EXP;
    tick();
    chk("run_entry_cpu_rst", cpu_rst, 0);
    chk("boot_dbg_ignored", pass, 0);
    dbg_data = 32'h0;
    tick();
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_in_run_ready", ld_ready, 0);
    chk("start_in_run_cpu_rst", cpu_rst, 0);
    repeat (6) tick();
    chk("run10_no_pass", pass, 0);
    dbg_data = EXP;
    tick();
    dbg_data = 32'h0;
    chk("p1_pass", pass, 1);
    chk("p1_fail", fail, 0);
    chk("p1_done_busy", busy, 0);
    chk("p1_done_cpu_rst", cpu_rst, 1);
    tick();
    tick();
    chk("p1_pass_hold", pass, 1);

    // Restart from DONE, then fill with toggling ld_valid and no ld_last
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("restart_pass_clr", pass, 0);
    chk("restart_ready", ld_ready, 1);
    chk("restart_wptr", im_waddr, 0);
    for (int i = 0; i < DEPTH; i++) begin
      ld_valid = 1'b1;
      ld_data  = 32'hB000_0000 + i;
      #1;
      chk("fill_we", im_we, 1);
      chk("fill_waddr", im_waddr, i);
      tick();
      ld_valid = 1'b0;
      #1;
      chk("fill_idle_we", im_we, 0);
      tick();
    end
    ld_valid = 1'b1;
    #1;
    chk("fill_65_ready", ld_ready, 0);
    chk("fill_65_we", im_we, 0);
    ld_valid = 1'b0;
    tick();
    chk("fill_run_cpu_rst", cpu_rst, 0);

    // Match on the same cycle the run counter reaches TIMEOUT
    repeat (TMO) tick();
    chk("simul_pre_pass", pass, 0);
    chk("simul_pre_busy", busy, 1);
    dbg_data = EXP;
    tick();
    dbg_data = 32'h0;
    chk("simul_pass", pass, 1);
    chk("simul_fail", fail, 0);

    // Asynchronous reset in RUN cycle 5
    load_and_boot(1);
    chk("rr_run", cpu_rst, 0);
    repeat (4) tick();
    chk("rr_busy_pre", busy, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("rr_cpu_rst", cpu_rst, 1);
    chk("rr_busy", busy, 0);
    chk("rr_ready", ld_ready, 0);
    chk("rr_pass", pass, 0);
    chk("rr_fail", fail, 0);
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    chk("rr_idle_busy", busy, 0);
    chk("rr_idle_cpu_rst", cpu_rst, 1);

    // Watchdog
    load_and_boot(2);
    dbg_data = 32'h0;
`ifdef SR_RUN_CTRL_WATCHDOG_EN
    repeat (TMO) tick();
    chk("wd_pre_fail", fail, 0);
    chk("wd_pre_busy", busy, 1);
    tick();
    chk("wd_fail", fail, 1);
    chk("wd_pass", pass, 0);
    chk("wd_busy", busy, 0);
    chk("wd_cpu_rst", cpu_rst, 1);
    repeat (3) tick();
    chk("wd_fail_hold", fail, 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("wd_fail_clr", fail, 0);
    chk("wd_reload_ready", ld_ready, 1);
`else
    repeat (1000) tick();
    chk("nowd_fail", fail, 0);
    chk("nowd_busy", busy, 1);
    chk("nowd_cpu_rst", cpu_rst, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sr_run_ctrl.md
SR_RUN_CTRL -- requirements
Module: sr_run_ctrl

Interface
REQ-001 SHALL have parameter IMEM_DEPTH, default 64, the number of instruction RAM words (power of two, 2..1024).
REQ-002 SHALL have parameter EXPECT, default 32'h00213d05, the debug-register value that signals pass.
REQ-003 SHALL have parameter DBG_REG, default 10, the debug register index (a0).
REQ-004 SHALL have parameter TIMEOUT, default 255, the RUN-cycle limit before fail.
REQ-005 SHALL have ports:
clk  in  1  clock; all state changes on the rising edge
rst_n  in  1  asynchronous, active-low reset
start  in  1  one-cycle request to begin load-and-run
ld_valid  in  1  load word valid
ld_ready  out  1  controller accepts a load word
ld_data  in  32  instruction word
ld_last  in  1  final word of program, qualified by ld_valid
im_we  out  1  instruction RAM write enable
im_waddr  out  $clog2(IMEM_DEPTH)  instruction RAM word address
im_wdata  out  32  instruction RAM write data
cpu_rst  out  1  active-high CPU reset
dbg_addr  out  5  CPU debug register address; constant DBG_REG
dbg_data  in  32  CPU debug register data
busy  out  1  state is LOAD, BOOT or RUN
pass  out  1  sticky pass flag
fail  out  1  sticky fail flag

Function
REQ-006 SHALL implement FSM states IDLE, LOAD, BOOT, RUN and DONE.
REQ-007 In IDLE, start SHALL move the FSM to LOAD and clear wptr, pass and fail; start SHALL be ignored while busy=1.
REQ-008 In DONE, start SHALL behave as in IDLE, so the block re-loads and re-runs.
REQ-009 ld_ready SHALL be 1 only in LOAD.
REQ-010 A transfer SHALL occur when ld_valid=1 and ld_ready=1 in the same cycle; ld_data SHALL be held externally until the transfer.
REQ-011 im_we SHALL equal ld_valid & ld_ready, combinationally.
REQ-012 im_waddr SHALL equal wptr and im_wdata SHALL equal ld_data, combinationally.
REQ-013 wptr SHALL increment by 1 on each transfer.
REQ-014 A transfer with ld_last=1, or a transfer at wptr=IMEM_DEPTH-1, SHALL end LOAD and move the FSM to BOOT on the next edge; no wrap-around write SHALL ever occur.
REQ-015 BOOT SHALL last exactly 2 cycles with cpu_rst=1, then move to RUN; the run counter SHALL be cleared on BOOT entry.
REQ-016 cpu_rst SHALL be 0 only in RUN, and 1 in all other states.
REQ-017 In RUN, the 8-bit-or-wider run counter SHALL increment each cycle and saturate at TIMEOUT.
REQ-018 In RUN, dbg_data==EXPECT sampled on an edge SHALL set pass=1 and move the FSM to DONE.
REQ-019 If the match and the timeout condition occur in the same cycle, pass SHALL win and fail SHALL stay 0.
REQ-020 pass and fail SHALL never both be 1.
REQ-021 Both flags SHALL hold their value in DONE until the next accepted start.
REQ-022 dbg_data SHALL be ignored outside RUN.

Reset
REQ-023 rst_n=0 SHALL asynchronously force: state=IDLE, wptr=0, run counter=0, pass=0, fail=0, cpu_rst=1, ld_ready=0, im_we=0, busy=0.
REQ-024 Reset asserted mid-LOAD or mid-RUN SHALL abort immediately; no partial state SHALL survive deassertion.
REQ-025 After rst_n deasserts, the block SHALL remain in IDLE until start.

Configuration
REQ-026 Macro SR_RUN_CTRL_WATCHDOG_EN SHALL control the timeout.
REQ-027 Defined: in RUN, run counter==TIMEOUT with no match SHALL set fail=1 and move the FSM to DONE.
REQ-028 Undefined: fail SHALL be tied to 0, RUN SHALL exit only on a match, and the run counter SHALL still saturate.

Verification
REQ-029 Load-and-pass: reset, start, 4 words with ld_last on the 4th and ld_valid held high -> im_we for 4 cycles at im_waddr 0..3; BOOT 2 cycles; cpu_rst falls; dbg_data=32'h00213d05 on RUN cycle 10 -> pass=1, state DONE, cpu_rst=1.
REQ-030 Backpressure and fill: ld_valid toggled 1/0 for 64 words with no ld_last -> exactly 64 writes at addresses 0..63; 65th ld_valid not accepted (ld_ready=0).
REQ-031 Watchdog (macro defined): dbg_data never matches -> fail=1 exactly TIMEOUT+1 RUN cycles after RUN entry. Macro undefined: fail stays 0 after 1000 cycles and busy stays 1.
REQ-032 Simultaneous events: match on the same cycle the counter reaches TIMEOUT -> pass=1 and fail=0. start pulsed during RUN -> ignored.
REQ-033 Reset mid-run: rst_n low for 1 cycle in RUN cycle 5 -> all outputs at reset values that same cycle (asynchronously); IDLE after release; pass=0.
REQ-034 Restart: start in DONE after pass -> pass cleared, LOAD entered, wptr=0, second program completes with pass.
